// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller uses the master side; the datapath (or a bench) the slave side.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             PCWr;
  logic             IRWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic [1:0]       RegDst;
  logic [1:0]       WDSel;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       EXTOp;
  logic [1:0]       PCSource;
  logic [4:0]       ALUOp;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  Op, Funct, Zero,
    output PCWr, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, state, illegal, instr_cnt
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWr, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, state, illegal, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM over FETCH..JUMP plus a retired-instruction
// counter. State and counter are registered; control lines decode state, Op and Funct.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      rstn,
  mc_ctrl_if.master bus
);

  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADD  = 5'd1;
  localparam logic [4:0] ALUOp_ADDU = 5'd2;
  localparam logic [4:0] ALUOp_SUB  = 5'd3;
  localparam logic [4:0] ALUOp_SUBU = 5'd4;
  localparam logic [4:0] ALUOp_AND  = 5'd5;
  localparam logic [4:0] ALUOp_OR   = 5'd6;
  localparam logic [4:0] ALUOp_XOR  = 5'd7;
  localparam logic [4:0] ALUOp_NOR  = 5'd8;
  localparam logic [4:0] ALUOp_SLT  = 5'd9;
  localparam logic [4:0] ALUOp_SLTU = 5'd10;
  localparam logic [4:0] ALUOp_SLL  = 5'd11;
  localparam logic [4:0] ALUOp_SRL  = 5'd12;
  localparam logic [4:0] ALUOp_SRA  = 5'd13;
  localparam logic [4:0] ALUOp_SLLV = 5'd14;
  localparam logic [4:0] ALUOp_SRLV = 5'd15;
  localparam logic [4:0] ALUOp_SRAV = 5'd16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  function automatic logic rtype_legal(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
        rtype_legal = 1'b1;
      default: rtype_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] rtype_aluop(input logic [5:0] fn);
    case (fn)
      FN_ADD:  rtype_aluop = ALUOp_ADD;
      FN_ADDU: rtype_aluop = ALUOp_ADDU;
      FN_SUB:  rtype_aluop = ALUOp_SUB;
      FN_SUBU: rtype_aluop = ALUOp_SUBU;
      FN_AND:  rtype_aluop = ALUOp_AND;
      FN_OR:   rtype_aluop = ALUOp_OR;
      FN_XOR:  rtype_aluop = ALUOp_XOR;
      FN_NOR:  rtype_aluop = ALUOp_NOR;
      FN_SLT:  rtype_aluop = ALUOp_SLT;
      FN_SLTU: rtype_aluop = ALUOp_SLTU;
      FN_SLL:  rtype_aluop = ALUOp_SLL;
      FN_SRL:  rtype_aluop = ALUOp_SRL;
      FN_SRA:  rtype_aluop = ALUOp_SRA;
      FN_SLLV: rtype_aluop = ALUOp_SLLV;
      FN_SRLV: rtype_aluop = ALUOp_SRLV;
      FN_SRAV: rtype_aluop = ALUOp_SRAV;
      default: rtype_aluop = ALUOp_NOP;
    endcase
  endfunction

  function automatic logic [4:0] itype_aluop(input logic [5:0] op);
    case (op)
      OP_ADDI:  itype_aluop = ALUOp_ADD;
      OP_ADDIU: itype_aluop = ALUOp_ADDU;
      OP_SLTI:  itype_aluop = ALUOp_SLT;
      OP_SLTIU: itype_aluop = ALUOp_SLTU;
      OP_ANDI:  itype_aluop = ALUOp_AND;
      OP_ORI:   itype_aluop = ALUOp_OR;
      OP_XORI:  itype_aluop = ALUOp_XOR;
      default:  itype_aluop = ALUOp_NOP;
    endcase
  endfunction

  function automatic logic itype_alu(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        itype_alu = 1'b1;
      default: itype_alu = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] itype_ext(input logic [5:0] op);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: itype_ext = 2'b00;
      OP_LUI:                   itype_ext = 2'b10;
      default:                  itype_ext = 2'b01;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_t     w_dec_next;
  logic       w_dec_illegal;
  logic       w_retire;
  logic       w_is_rtype;
  logic [1:0] w_exe_src_a;
  logic [1:0] w_exe_src_b;
  logic [1:0] w_exe_ext;
  logic [4:0] w_exe_aluop;

  logic       w_pc_wr;
  logic       w_ir_write;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_wd_sel;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_ext_op;
  logic [1:0] w_pc_source;
  logic [4:0] w_aluop;
  logic       w_illegal;

  assign w_is_rtype = (bus.Op == OP_RTYPE);
  assign w_retire   = (r_state == S_MEMWB) || (r_state == S_MEMWR) || (r_state == S_ALUWB) ||
                      (r_state == S_BRANCH) || (r_state == S_JUMP);

  // Opcode dispatch out of DECODE.
  always_comb begin
    w_dec_next    = S_FETCH;
    w_dec_illegal = 1'b0;
    case (bus.Op)
      OP_LW, OP_SW:   w_dec_next = S_MEMADR;
      OP_BEQ, OP_BNE: w_dec_next = S_BRANCH;
      OP_J, OP_JAL:   w_dec_next = S_JUMP;
      OP_RTYPE: begin
        if (bus.Funct == FN_JR) begin
          w_dec_next = S_JUMP;
        end else if (rtype_legal(bus.Funct)) begin
          w_dec_next = S_EXE;
        end else begin
          w_dec_illegal = 1'b1;
        end
      end
      default: begin
        if (itype_alu(bus.Op)) begin
          w_dec_next = S_EXE;
        end else begin
          w_dec_illegal = 1'b1;
        end
      end
    endcase
  end

  // ALU setup shared by EXE and ALUWB so the result stays stable through writeback.
  always_comb begin
    if (w_is_rtype) begin
      w_exe_src_a = ((bus.Funct == FN_SLL) || (bus.Funct == FN_SRL) || (bus.Funct == FN_SRA)) ?
                    2'b10 : 2'b01;
      w_exe_src_b = 2'b00;
      w_exe_ext   = 2'b00;
      w_exe_aluop = rtype_aluop(bus.Funct);
    end else begin
      w_exe_src_a = 2'b01;
      w_exe_src_b = 2'b10;
      w_exe_ext   = itype_ext(bus.Op);
      w_exe_aluop = itype_aluop(bus.Op);
    end
  end

  // State register and retire counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      if (w_retire) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: r_state <= w_dec_next;
        S_MEMADR: r_state <= (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXE:    r_state <= S_ALUWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state control decode.
  always_comb begin
    w_pc_wr     = 1'b0;
    w_ir_write  = 1'b0;
    w_iord      = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_reg_dst   = 2'b00;
    w_wd_sel    = 2'b00;
    w_alu_src_a = 2'b00;
    w_alu_src_b = 2'b00;
    w_ext_op    = 2'b00;
    w_pc_source = 2'b00;
    w_aluop     = ALUOp_NOP;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_pc_wr     = 1'b1;
        w_alu_src_b = 2'b01;
        w_aluop     = ALUOp_ADD;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_ext_op    = 2'b01;
        w_aluop     = ALUOp_ADD;
        w_illegal   = w_dec_illegal;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_ext_op    = 2'b01;
        w_aluop     = ALUOp_ADD;
      end
      S_MEMRD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        w_wd_sel    = 2'b01;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXE: begin
        w_alu_src_a = w_exe_src_a;
        w_alu_src_b = w_exe_src_b;
        w_ext_op    = w_exe_ext;
        w_aluop     = w_exe_aluop;
      end
      S_ALUWB: begin
        w_alu_src_a = w_exe_src_a;
        w_alu_src_b = w_exe_src_b;
        w_ext_op    = w_exe_ext;
        w_aluop     = w_exe_aluop;
        w_reg_write = 1'b1;
        w_reg_dst   = w_is_rtype ? 2'b01 : 2'b00;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b01;
        w_aluop     = ALUOp_SUB;
        w_pc_source = 2'b01;
        w_pc_wr     = (bus.Op == OP_BNE) ? ~bus.Zero : bus.Zero;
      end
      S_JUMP: begin
        w_pc_wr     = 1'b1;
        w_pc_source = w_is_rtype ? 2'b11 : 2'b10;
        w_reg_write = (bus.Op == OP_JAL);
        w_reg_dst   = (bus.Op == OP_JAL) ? 2'b10 : 2'b00;
        w_wd_sel    = (bus.Op == OP_JAL) ? 2'b10 : 2'b00;
      end
      default: begin
        w_aluop = ALUOp_NOP;
      end
    endcase
  end

  // Strobes are held low while reset is asserted even though FETCH is decoded.
  assign bus.PCWr      = w_pc_wr     & rstn;
  assign bus.IRWrite   = w_ir_write  & rstn;
  assign bus.MemRead   = w_mem_read  & rstn;
  assign bus.MemWrite  = w_mem_write & rstn;
  assign bus.RegWrite  = w_reg_write & rstn;
  assign bus.illegal   = w_illegal   & rstn;
  assign bus.IorD      = w_iord;
  assign bus.RegDst    = w_reg_dst;
  assign bus.WDSel     = w_wd_sel;
  assign bus.ALUSrcA   = w_alu_src_a;
  assign bus.ALUSrcB   = w_alu_src_b;
  assign bus.EXTOp     = w_ext_op;
  assign bus.PCSource  = w_pc_source;
  assign bus.ALUOp     = w_aluop;
  assign bus.state     = r_state;
  assign bus.instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each instruction pushes its expected per-cycle control
// vectors; a negedge monitor pops and compares them against the live outputs.
module tb_mc_ctrl;
  localparam int CNT_W = 4;

  localparam logic [4:0] A_NOP  = 5'd0;
  localparam logic [4:0] A_ADD  = 5'd1;
  localparam logic [4:0] A_SUB  = 5'd3;
  localparam logic [4:0] A_AND  = 5'd5;
  localparam logic [4:0] A_XOR  = 5'd7;
  localparam logic [4:0] A_NOR  = 5'd8;
  localparam logic [4:0] A_SLTU = 5'd10;
  localparam logic [4:0] A_SLL  = 5'd11;
  localparam logic [4:0] A_SRA  = 5'd13;
  localparam logic [4:0] A_SRLV = 5'd15;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] en;   // {PCWr, IRWrite, IorD, MemRead, MemWrite, RegWrite}
    logic [1:0] rd;
    logic [1:0] wd;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] ext;
    logic [1:0] ps;
    logic [4:0] aop;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    ctl_t             ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mc_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  exp_t             sb_q[$];
  int               n_total = 0;
  int               n_bad   = 0;
  logic [CNT_W-1:0] m_cnt   = '0;
  ctl_t             w_obs;

  assign w_obs = {bus.state, bus.PCWr, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.RegWrite, bus.RegDst, bus.WDSel, bus.ALUSrcA, bus.ALUSrcB, bus.EXTOp,
                  bus.PCSource, bus.ALUOp, bus.illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ctl_t mk(input logic [3:0] st, input logic [5:0] en,
                              input logic [1:0] rd, input logic [1:0] wd,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] ext, input logic [1:0] ps,
                              input logic [4:0] aop, input logic ill);
    return {st, en, rd, wd, sa, sb, ext, ps, aop, ill};
  endfunction

  task automatic push(input ctl_t c, input bit retire);
    exp_t e;
    e.ctl = c;
    e.cnt = m_cnt;
    sb_q.push_back(e);
    if (retire) m_cnt = m_cnt + 1'b1;
  endtask

  function automatic bit rlegal(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Called just after an edge with the DUT in FETCH; aop/ext/sa are the EXE expectations.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic [4:0] aop, input logic [1:0] ext, input logic [1:0] sa);
    int n;
    bit ill;
    ill = 1'b0;
    bus.Op    = op;
    bus.Funct = fn;
    bus.Zero  = z;
    if (op == 6'h00) ill = (fn != 6'h08) && !rlegal(fn);
    else if (!(op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03}) &&
             !(op >= 6'h08 && op <= 6'h0F)) ill = 1'b1;
    push(mk(4'd0, 6'b110100, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, A_ADD, 1'b0), 1'b0);
    push(mk(4'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, A_ADD, ill), 1'b0);
    n = 2;
    if (ill) begin
      n = 2;
    end else if (op == 6'h23 || op == 6'h2B) begin
      push(mk(4'd2, 6'b000000, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, A_ADD, 1'b0), 1'b0);
      if (op == 6'h23) begin
        push(mk(4'd3, 6'b001100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, A_NOP, 1'b0), 1'b0);
        push(mk(4'd4, 6'b000001, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, A_NOP, 1'b0), 1'b1);
        n = 5;
      end else begin
        push(mk(4'd5, 6'b001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, A_NOP, 1'b0), 1'b1);
        n = 4;
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      push(mk(4'd9, 6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, A_NOP, 1'b0), 1'b1);
      n = 3;
    end else if (op == 6'h00) begin
      push(mk(4'd6, 6'b000000, 2'b00, 2'b00, sa, 2'b00, 2'b00, 2'b00, aop, 1'b0), 1'b0);
      push(mk(4'd7, 6'b000001, 2'b01, 2'b00, sa, 2'b00, 2'b00, 2'b00, aop, 1'b0), 1'b1);
      n = 4;
    end else if (op == 6'h04 || op == 6'h05) begin
      push(mk(4'd8, {(op == 6'h04) ? z : ~z, 5'b00000}, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00,
              2'b01, A_SUB, 1'b0), 1'b1);
      n = 3;
    end else if (op == 6'h02) begin
      push(mk(4'd9, 6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, A_NOP, 1'b0), 1'b1);
      n = 3;
    end else if (op == 6'h03) begin
      push(mk(4'd9, 6'b100001, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, A_NOP, 1'b0), 1'b1);
      n = 3;
    end else begin
      push(mk(4'd6, 6'b000000, 2'b00, 2'b00, 2'b01, 2'b10, ext, 2'b00, aop, 1'b0), 1'b0);
      push(mk(4'd7, 6'b000001, 2'b00, 2'b00, 2'b01, 2'b10, ext, 2'b00, aop, 1'b0), 1'b1);
      n = 4;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("state", 32'(bus.state), 32'(e.ctl.st));
      check("ctl", 32'(w_obs), 32'(e.ctl));
      check("cnt", 32'(bus.instr_cnt), 32'(e.cnt));
    end
  end

  initial begin
    bus.Op    = 6'h00;
    bus.Funct = 6'h00;
    bus.Zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_cnt", 32'(bus.instr_cnt), 32'd0);
    check("rst_strobes", 32'({bus.PCWr, bus.IRWrite, bus.MemRead, bus.MemWrite,
                              bus.RegWrite, bus.illegal}), 32'd0);
    rstn = 1'b1;

    run_instr(6'h00, 6'h20, 1'b0, A_ADD,  2'b00, 2'b01);  // add
    run_instr(6'h00, 6'h22, 1'b0, A_SUB,  2'b00, 2'b01);  // sub
    run_instr(6'h00, 6'h00, 1'b0, A_SLL,  2'b00, 2'b10);  // sll
    run_instr(6'h00, 6'h03, 1'b0, A_SRA,  2'b00, 2'b10);  // sra
    run_instr(6'h00, 6'h06, 1'b0, A_SRLV, 2'b00, 2'b01);  // srlv
    run_instr(6'h00, 6'h27, 1'b0, A_NOR,  2'b00, 2'b01);  // nor
    run_instr(6'h00, 6'h2B, 1'b0, A_SLTU, 2'b00, 2'b01);  // sltu
    run_instr(6'h23, 6'h11, 1'b0, A_NOP,  2'b00, 2'b00);  // lw
    run_instr(6'h2B, 6'h05, 1'b0, A_NOP,  2'b00, 2'b00);  // sw
    run_instr(6'h08, 6'h3F, 1'b0, A_ADD,  2'b01, 2'b01);  // addi
    run_instr(6'h0C, 6'h00, 1'b0, A_AND,  2'b00, 2'b01);  // andi
    run_instr(6'h0F, 6'h00, 1'b0, A_NOP,  2'b10, 2'b01);  // lui
    run_instr(6'h0B, 6'h00, 1'b0, A_SLTU, 2'b01, 2'b01);  // sltiu
    run_instr(6'h0E, 6'h00, 1'b0, A_XOR,  2'b00, 2'b01);  // xori
    run_instr(6'h04, 6'h00, 1'b1, A_NOP,  2'b00, 2'b00);  // beq taken
    run_instr(6'h04, 6'h00, 1'b0, A_NOP,  2'b00, 2'b00);  // beq not taken
    run_instr(6'h05, 6'h00, 1'b1, A_NOP,  2'b00, 2'b00);  // bne not taken
    run_instr(6'h05, 6'h00, 1'b0, A_NOP,  2'b00, 2'b00);  // bne taken
    run_instr(6'h02, 6'h00, 1'b0, A_NOP,  2'b00, 2'b00);  // j
    run_instr(6'h03, 6'h00, 1'b0, A_NOP,  2'b00, 2'b00);  // jal
    run_instr(6'h00, 6'h08, 1'b0, A_NOP,  2'b00, 2'b00);  // jr
    run_instr(6'h3F, 6'h00, 1'b0, A_NOP,  2'b00, 2'b00);  // illegal opcode
    run_instr(6'h00, 6'h01, 1'b0, A_NOP,  2'b00, 2'b00);  // illegal funct

    // Abandon an add in EXE with an asynchronous reset.
    bus.Op    = 6'h00;
    bus.Funct = 6'h20;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_state", 32'(bus.state), 32'd6);
    check("pre_rst_cnt", 32'(bus.instr_cnt), 32'(m_cnt));
    #2 rstn = 1'b0;
    #1;
    check("async_state", 32'(bus.state), 32'd0);
    check("async_cnt", 32'(bus.instr_cnt), 32'd0);
    check("async_strobes", 32'({bus.PCWr, bus.IRWrite, bus.MemRead, bus.MemWrite,
                                bus.RegWrite, bus.illegal}), 32'd0);
    @(posedge clk);
    #1;
    check("held_state", 32'(bus.state), 32'd0);
    check("held_strobes", 32'({bus.PCWr, bus.IRWrite, bus.MemRead, bus.MemWrite,
                               bus.RegWrite, bus.illegal}), 32'd0);
    m_cnt = '0;
    rstn  = 1'b1;

    // Sixteen retires (plus one illegal) bring the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      case (i % 6)
        0: run_instr(6'h00, 6'h24, 1'b0, A_AND, 2'b00, 2'b01);
        1: run_instr(6'h23, 6'h00, 1'b0, A_NOP, 2'b00, 2'b00);
        2: run_instr(6'h05, 6'h00, 1'($urandom_range(0, 1)), A_NOP, 2'b00, 2'b00);
        3: run_instr(6'h2B, 6'h00, 1'b0, A_NOP, 2'b00, 2'b00);
        4: run_instr(6'h09, 6'h00, 1'b0, 5'd2, 2'b01, 2'b01);
        default: run_instr(6'h03, 6'h00, 1'b0, A_NOP, 2'b00, 2'b00);
      endcase
      if (i == 7) run_instr(6'h11, 6'h00, 1'b0, A_NOP, 2'b00, 2'b00);
    end
    check("wrap_cnt", 32'(bus.instr_cnt), 32'd0);
    check("wrap_state", 32'(bus.state), 32'd0);

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
